// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, synchronous flush, bubble gating and a
// saturating stall counter. Define ID_EX_SKID_EN to add a one-entry skid buffer (registered in_ready).
module id_ex_pipe_stage #(
   parameter int               XLEN      = 32,
   parameter int               RA_W      = 5,
   parameter int               ALUC_W    = 4,
   parameter logic [XLEN-1:0]  NOP_INSTR = 32'h00000013,
   parameter int               CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic              load_in,
   input  logic              store_in,
   input  logic              next_sel_in,
   input  logic              branch_result_in,
   input  logic              reg_write_in,
   input  logic [RA_W-1:0]   rs1_in,
   input  logic [RA_W-1:0]   rs2_in,
   input  logic [ALUC_W-1:0] alu_control_in,
   input  logic [1:0]        mem_to_reg_in,
   input  logic [XLEN-1:0]   opa_in,
   input  logic [XLEN-1:0]   opb_in,
   input  logic [XLEN-1:0]   opb_data_in,
   input  logic [XLEN-1:0]   pc_in,
   input  logic [XLEN-1:0]   instruction_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              load,
   output logic              store,
   output logic              next_sel,
   output logic              branch_result,
   output logic              reg_write_out,
   output logic [RA_W-1:0]   rs1_out,
   output logic [RA_W-1:0]   rs2_out,
   output logic [ALUC_W-1:0] alu_control,
   output logic [1:0]        mem_to_reg,
   output logic [XLEN-1:0]   opa_out,
   output logic [XLEN-1:0]   opb_out,
   output logic [XLEN-1:0]   opb_data_out,
   output logic [XLEN-1:0]   pc_out,
   output logic [XLEN-1:0]   instruction_out,
   output logic [CNT_W-1:0]  stall_count
);

   // Whole entry travels as one vector; instruction occupies the low XLEN bits.
   localparam int              PW     = 5 + 2*RA_W + ALUC_W + 2 + 5*XLEN;
   localparam logic [PW-1:0]   PL_RST = {{(PW-XLEN){1'b0}}, NOP_INSTR};

   logic [PW-1:0]    in_pl;
   logic [PW-1:0]    main_q, main_d;
   logic             main_valid_q, main_valid_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             accept, pop;

   logic             f_load, f_store, f_next_sel, f_branch, f_reg_write;
   logic [XLEN-1:0]  f_instr;

   assign in_pl = {load_in, store_in, next_sel_in, branch_result_in, reg_write_in,
                   rs1_in, rs2_in, alu_control_in, mem_to_reg_in,
                   opa_in, opb_in, opb_data_in, pc_in, instruction_in};

   assign pop    = main_valid_q & out_ready;
   assign accept = in_valid & in_ready;

`ifdef ID_EX_SKID_EN
   logic [PW-1:0] skid_q, skid_d;
   logic          skid_valid_q, skid_valid_d;

   assign in_ready = rst_n & ~skid_valid_q;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         main_d       = {main_q[PW-1:XLEN], NOP_INSTR};
      end else if (skid_valid_q) begin
         if (pop) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         // A held main entry pushes the newcomer into the skid slot.
         if (main_valid_q && !pop) begin
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
         end else begin
            main_d       = in_pl;
            main_valid_d = 1'b1;
         end
      end else if (pop) begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`else
   assign in_ready = rst_n & (out_ready | ~main_valid_q);

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         main_d       = {main_q[PW-1:XLEN], NOP_INSTR};
      end else if (accept) begin
         main_d       = in_pl;
         main_valid_d = 1'b1;
      end else if (pop) begin
         main_valid_d = 1'b0;
      end
   end
`endif

   always_comb begin
      stall_d = stall_q;
      if (main_valid_q && !out_ready && !(&stall_q)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q       <= PL_RST;
         main_valid_q <= 1'b0;
         stall_q      <= '0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         stall_q      <= stall_d;
      end
   end

   assign {f_load, f_store, f_next_sel, f_branch, f_reg_write,
           rs1_out, rs2_out, alu_control, mem_to_reg,
           opa_out, opb_out, opb_data_out, pc_out, f_instr} = main_q;

   // Side-effecting controls are squashed for bubbles so EX never acts on stale data.
   assign out_valid       = main_valid_q;
   assign load            = f_load      & main_valid_q;
   assign store           = f_store     & main_valid_q;
   assign next_sel        = f_next_sel  & main_valid_q;
   assign branch_result   = f_branch    & main_valid_q;
   assign reg_write_out   = f_reg_write & main_valid_q;
   assign instruction_out = main_valid_q ? f_instr : NOP_INSTR;
   assign stall_count     = stall_q;

endmodule
